alu_seq: RTL and testbench

- Parametrised, handshaked successor to the single-op datapath adder.
- Accepts an opcode and two WIDTH-bit operands on a valid/ready input channel.
- Computes one of eight operations and presents a registered result plus flags on a valid/ready output channel.
- Sits between register-read and write-back; single-cycle ops stream back-to-back, multiply is multi-cycle via an internal state machine.

---
 rtl/alu_seq.sv | 200 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked eight-op ALU: single-cycle ops stream back-to-back, MUL is a shift-add FSM.
// Define ALU_MUL_EN to build the multiply datapath; otherwise ALUOp=111 behaves as NOP.
module alu_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             InValid,
  output logic             InReady,
  input  logic [2:0]       ALUOp,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic             Zero,
  output logic             Carry,
  output logic             Overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam int unsigned MSB = WIDTH - 1;

  logic [1:0]       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             xfer;

  // Single-cycle datapath
  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] op_res;
  logic             op_c, op_v, op_z, is_nop;

  assign InReady = (state_q == S_IDLE) || ((state_q == S_DONE) && OutReady);
  assign xfer    = InValid && InReady;

  assign add_w = {1'b0, OperandA} + {1'b0, OperandB};
  assign sub_w = {1'b0, OperandA} - {1'b0, OperandB};

`ifdef ALU_MUL_EN
  assign is_nop = (ALUOp == OP_NOP);
`else
  assign is_nop = (ALUOp == OP_NOP) || (ALUOp == OP_MUL);
`endif

  always_comb begin
    op_res = '0;
    op_c   = 1'b0;
    op_v   = 1'b0;
    case (ALUOp)
      OP_ADD: begin
        op_res = add_w[WIDTH-1:0];
        op_c   = add_w[WIDTH];
        op_v   = (OperandA[MSB] == OperandB[MSB]) && (add_w[MSB] != OperandA[MSB]);
      end
      OP_SUB: begin
        op_res = sub_w[WIDTH-1:0];
        op_c   = sub_w[WIDTH];
        op_v   = (OperandA[MSB] != OperandB[MSB]) && (sub_w[MSB] != OperandA[MSB]);
      end
      OP_AND: op_res = OperandA & OperandB;
      OP_OR:  op_res = OperandA | OperandB;
      OP_XOR: op_res = OperandA ^ OperandB;
      OP_SLT: op_res = {{(WIDTH-1){1'b0}}, ($signed(OperandA) < $signed(OperandB))};
      default: op_res = '0;
    endcase
    // NOP reports every flag clear, including Zero.
    op_z = !is_nop && (op_res == '0);
  end

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  // Upper half accumulates partial sums; lower half shifts the multiplier out LSB-first.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_step;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign acc_step = {mul_sum, acc_q[WIDTH-1:1]};
  assign ResultHi = result_hi_q;
`else
  assign ResultHi = '0;
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
`ifdef ALU_MUL_EN
    result_hi_d = result_hi_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
`endif
    if (state_q == S_MUL) begin
`ifdef ALU_MUL_EN
      acc_d = acc_step;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d     = S_DONE;
        result_d    = acc_step[WIDTH-1:0];
        result_hi_d = acc_step[2*WIDTH-1:WIDTH];
        zero_d      = (acc_step[WIDTH-1:0] == '0);
        carry_d     = 1'b0;
        ovf_d       = (acc_step[2*WIDTH-1:WIDTH] != '0);
      end
`else
      state_d = S_IDLE;
`endif
    end else if (xfer) begin
`ifdef ALU_MUL_EN
      if (ALUOp == OP_MUL) begin
        state_d = S_MUL;
        mcand_d = OperandA;
        acc_d   = {{WIDTH{1'b0}}, OperandB};
        cnt_d   = CNT_W'(WIDTH);
      end else begin
        state_d     = S_DONE;
        result_d    = op_res;
        result_hi_d = '0;
        zero_d      = op_z;
        carry_d     = op_c;
        ovf_d       = op_v;
      end
`else
      state_d  = S_DONE;
      result_d = op_res;
      zero_d   = op_z;
      carry_d  = op_c;
      ovf_d    = op_v;
`endif
    end else if ((state_q == S_DONE) && OutReady) begin
      state_d = S_IDLE;
    end
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef ALU_MUL_EN
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      result_hi_q <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      result_hi_q <= result_hi_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end
`endif

  assign OutValid = out_valid_q;
  assign Result   = result_q;
  assign Zero     = zero_q;
  assign Carry    = carry_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8; MUL checks follow ALU_MUL_EN.
module tb_alu_seq;

  logic       Clk;
  logic       ResetN;
  logic       InValid;
  logic       InReady;
  logic [2:0] ALUOp;
  logic [7:0] OperandA;
  logic [7:0] OperandB;
  logic       OutValid;
  logic       OutReady;
  logic [7:0] Result;
  logic [7:0] ResultHi;
  logic       Zero;
  logic       Carry;
  logic       Overflow;

  int checks = 0;
  int errors = 0;

  alu_seq #(
    .WIDTH(8),
    .CNT_W(4)
  ) dut (
    .Clk      (Clk),
    .ResetN   (ResetN),
    .InValid  (InValid),
    .InReady  (InReady),
    .ALUOp    (ALUOp),
    .OperandA (OperandA),
    .OperandB (OperandB),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Result   (Result),
    .ResultHi (ResultHi),
    .Zero     (Zero),
    .Carry    (Carry),
    .Overflow (Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Present one request for exactly one edge; sample point is 1 time unit after that edge.
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    ALUOp    = op;
    OperandA = a;
    OperandB = b;
    InValid  = 1'b1;
    @(posedge Clk);
    #1;
    InValid  = 1'b0;
  endtask

  task automatic chk_flags(input string tag, input logic [7:0] res, input logic z,
                           input logic c, input logic v);
    chk({tag, ".valid"}, 16'(OutValid), 16'd1);
    chk({tag, ".res"},   16'(Result),   16'(res));
    chk({tag, ".zero"},  16'(Zero),     16'(z));
    chk({tag, ".carry"}, 16'(Carry),    16'(c));
    chk({tag, ".ovf"},   16'(Overflow), 16'(v));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".in_ready"},  16'(InReady),  16'd1);
    chk({tag, ".out_valid"}, 16'(OutValid), 16'd0);
    chk({tag, ".res"},       16'(Result),   16'd0);
    chk({tag, ".res_hi"},    16'(ResultHi), 16'd0);
    chk({tag, ".flags"},     16'({Zero, Carry, Overflow}), 16'd0);
  endtask

  initial begin
    ResetN   = 1'b1;
    InValid  = 1'b0;
    ALUOp    = 3'b000;
    OperandA = 8'h00;
    OperandB = 8'h00;
    OutReady = 1'b1;

    #2 ResetN = 1'b0;
    #1 chk_idle_outputs("reset");
    @(posedge Clk);
    #1 ResetN = 1'b1;

    issue(3'b001, 8'hF0, 8'h20);
    chk_flags("add_carry", 8'h10, 1'b0, 1'b1, 1'b0);
    chk("add_carry.hi", 16'(ResultHi), 16'd0);

    issue(3'b001, 8'h7F, 8'h01);
    chk_flags("add_ovf", 8'h80, 1'b0, 1'b0, 1'b1);

    issue(3'b010, 8'h05, 8'h05);
    chk_flags("sub_zero", 8'h00, 1'b1, 1'b0, 1'b0);

    issue(3'b010, 8'h03, 8'h05);
    chk_flags("sub_borrow", 8'hFE, 1'b0, 1'b1, 1'b0);

    issue(3'b110, 8'hFF, 8'h01);
    chk_flags("slt_neg", 8'h01, 1'b0, 1'b0, 1'b0);

    issue(3'b110, 8'h01, 8'hFF);
    chk_flags("slt_pos", 8'h00, 1'b1, 1'b0, 1'b0);

    issue(3'b000, 8'h03, 8'h04);
    chk_flags("nop", 8'h00, 1'b0, 1'b0, 1'b0);

    // Result consumed with nothing new behind it: back to idle.
    @(posedge Clk);
    #1;
    chk("drain.out_valid", 16'(OutValid), 16'd0);
    chk("drain.in_ready",  16'(InReady),  16'd1);

    // Back-pressure on an AND result while a XOR request waits.
    OutReady = 1'b0;
    issue(3'b011, 8'hF0, 8'h3C);
    chk_flags("and", 8'h30, 1'b0, 1'b0, 1'b0);
    chk("and.in_ready", 16'(InReady), 16'd0);
    ALUOp    = 3'b101;
    OperandA = 8'hAA;
    OperandB = 8'h0F;
    InValid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk);
      #1;
      chk("stall.res",       16'(Result),   16'h30);
      chk("stall.out_valid", 16'(OutValid), 16'd1);
      chk("stall.in_ready",  16'(InReady),  16'd0);
    end
    OutReady = 1'b1;
    #1 chk("release.in_ready", 16'(InReady), 16'd1);
    @(posedge Clk);
    #1;
    InValid = 1'b0;
    chk_flags("xor_no_bubble", 8'hA5, 1'b0, 1'b0, 1'b0);

    issue(3'b100, 8'h0F, 8'hF0);
    chk_flags("or_stream", 8'hFF, 1'b0, 1'b0, 1'b0);
    issue(3'b001, 8'h01, 8'h01);
    chk_flags("add_stream", 8'h02, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a cycle while a result is held.
    #1 ResetN = 1'b0;
    #1 chk_idle_outputs("reset_async");
    @(posedge Clk);
    #1 ResetN = 1'b1;

`ifdef ALU_MUL_EN
    issue(3'b111, 8'h0C, 8'h0B);
    for (int i = 1; i <= 8; i++) begin
      chk("mul1.busy_in_ready",  16'(InReady),  16'd0);
      chk("mul1.busy_out_valid", 16'(OutValid), 16'd0);
      @(posedge Clk);
      #1;
    end
    chk_flags("mul1", 8'h84, 1'b0, 1'b0, 1'b0);
    chk("mul1.hi", 16'(ResultHi), 16'h00);

    issue(3'b111, 8'hFF, 8'hFF);
    for (int i = 1; i <= 8; i++) begin
      chk("mul2.busy_in_ready", 16'(InReady), 16'd0);
      @(posedge Clk);
      #1;
    end
    chk_flags("mul2", 8'h01, 1'b0, 1'b0, 1'b1);
    chk("mul2.hi", 16'(ResultHi), 16'hFE);

    // Single-cycle op after MUL must clear the high word.
    issue(3'b011, 8'h0F, 8'h03);
    chk_flags("and_after_mul", 8'h03, 1'b0, 1'b0, 1'b0);
    chk("and_after_mul.hi", 16'(ResultHi), 16'h00);

    issue(3'b111, 8'hFF, 8'hFF);
    repeat (3) @(posedge Clk);
    #2 ResetN = 1'b0;
    #1 chk_idle_outputs("reset_mid_mul");
    @(posedge Clk);
    #1 ResetN = 1'b1;
    @(posedge Clk);
    #1 chk("post_reset.out_valid", 16'(OutValid), 16'd0);
`else
    issue(3'b001, 8'h01, 8'h01);
    chk_flags("pre_mulnop", 8'h02, 1'b0, 1'b0, 1'b0);
    issue(3'b111, 8'h03, 8'h04);
    chk_flags("mul_as_nop", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("mul_as_nop.hi", 16'(ResultHi), 16'h00);
    chk("mul_as_nop.in_ready", 16'(InReady), 16'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
